// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of a slow clock-like
// input (clk_meas) in clk_in cycles. It reports lock once the period has been
// stable for LOCK_COUNT consecutive samples and flags loss of signal when no
// rising edge arrives within TIMEOUT cycles.
module clk_period_meter #(
  parameter int          WIDTH      = 16,
  parameter int unsigned TIMEOUT    = 16'hFFFF,
  parameter int          LOCK_COUNT = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clk_meas,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             new_sample,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  // Counter ceiling; both counters stop here instead of wrapping.
  localparam logic [WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [WIDTH-1:0] TIMEOUT_VAL = WIDTH'(TIMEOUT);
  localparam logic [3:0]       LOCK_VAL    = 4'(LOCK_COUNT);
  localparam logic [WIDTH-1:0] CNT_ONE     = WIDTH'(1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state_reg;
  logic [2:0]       sync_reg;     // [0]=s1, [1]=s2, [2]=s3
  logic [WIDTH-1:0] per_cnt_reg;
  logic [WIDTH-1:0] hi_cnt_reg;
  logic [3:0]       match_cnt_reg;

  logic             s2;
  logic             s3;
  logic             rise;
  logic [3:0]       match_next;
  logic             period_equal;

  // s1/s2 form the metastability guard; s3 is only used for edge detection.
  assign s2   = sync_reg[1];
  assign s3   = sync_reg[2];
  assign rise = s2 & ~s3;

  // A sample only counts towards lock if a previous sample exists since the
  // last reset/timeout (valid) and it carries the same period.
  assign period_equal = valid && (per_cnt_reg == period);

  // Saturating successor of the consecutive-match counter.
  always_comb begin
    match_next = match_cnt_reg;
    if (match_cnt_reg < LOCK_VAL) begin
      match_next = match_cnt_reg + 4'd1;
    end else begin
      match_next = LOCK_VAL;
    end
  end

  // Three-stage input shift register; cleared by reset so that a stale level
  // cannot masquerade as history.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[1:0], clk_meas};
    end
  end

  // Measurement state machine: counting, sampling, lock tracking and timeout.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg     <= IDLE;
      per_cnt_reg   <= '0;
      hi_cnt_reg    <= '0;
      match_cnt_reg <= '0;
      period        <= '0;
      high_time     <= '0;
      new_sample    <= 1'b0;
      valid         <= 1'b0;
      locked        <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      new_sample <= 1'b0;
      case (state_reg)
        IDLE: begin
          per_cnt_reg <= '0;
          hi_cnt_reg  <= '0;
          // The first edge only arms the counters; no sample yet.
          if (rise) begin
            per_cnt_reg <= CNT_ONE;
            hi_cnt_reg  <= CNT_ONE;
            timeout     <= 1'b0;
            state_reg   <= MEASURE;
          end
        end

        MEASURE: begin
          if (rise) begin
            // An edge always wins over a coincident timeout.
            period      <= per_cnt_reg;
            high_time   <= hi_cnt_reg;
            new_sample  <= 1'b1;
            valid       <= 1'b1;
            per_cnt_reg <= CNT_ONE;
            hi_cnt_reg  <= CNT_ONE;
            if (period_equal) begin
              match_cnt_reg <= match_next;
              locked        <= (match_next == LOCK_VAL);
            end else begin
              match_cnt_reg <= '0;
              locked        <= 1'b0;
            end
          end else if (per_cnt_reg == TIMEOUT_VAL) begin
            // Loss of signal: drop back to IDLE, keep the last measurement.
            state_reg     <= IDLE;
            per_cnt_reg   <= '0;
            hi_cnt_reg    <= '0;
            match_cnt_reg <= '0;
            valid         <= 1'b0;
            locked        <= 1'b0;
            timeout       <= 1'b1;
          end else begin
            if (per_cnt_reg != CNT_MAX) begin
              per_cnt_reg <= per_cnt_reg + CNT_ONE;
            end
            if (s2 && (hi_cnt_reg != CNT_MAX)) begin
              hi_cnt_reg <= hi_cnt_reg + CNT_ONE;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
